// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin arbiter sharing one line-wide Avalon-MM memory port among PORTS cache controllers.
// Optional feature macro CACHE_ARB_WB_PRIO_EN: pending writebacks win arbitration over refills.
module cache_mem_arbiter #(
  parameter int PORTS     = 4,
  parameter int LINE_BITS = 128,
  parameter int ADDR_BITS = 32,
  localparam int IDX_W    = $clog2(PORTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORTS*ADDR_BITS-1:0] up_address,
  input  logic [PORTS-1:0]           up_read,
  input  logic [PORTS-1:0]           up_write,
  input  logic [PORTS*LINE_BITS-1:0] up_writedata,
  output logic [PORTS-1:0]           up_waitrequest,
  output logic [LINE_BITS-1:0]       up_readdata,
  output logic [ADDR_BITS-1:0]       down_address,
  output logic                       down_read,
  output logic                       down_write,
  output logic [LINE_BITS-1:0]       down_writedata,
  input  logic                       down_waitrequest,
  input  logic [LINE_BITS-1:0]       down_readdata,
  output logic                       grant_valid,
  output logic [IDX_W-1:0]           grant_idx
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [ADDR_BITS-1:0] slot_addr  [PORTS];
  logic [LINE_BITS-1:0] slot_wdata [PORTS];
  logic [IDX_W:0]       rot_sum    [PORTS];
  logic [IDX_W-1:0]     rot_idx    [PORTS];
  logic [PORTS-1:0]     req, cand;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 busy, g_req, g_read, g_write;
  logic [IDX_W-1:0]     rr_inc;

  // rot_idx[k] is the slot k positions after the rr pointer, wrapped into 0..PORTS-1.
  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_slot
      assign slot_addr[gi]  = up_address[gi*ADDR_BITS +: ADDR_BITS];
      assign slot_wdata[gi] = up_writedata[gi*LINE_BITS +: LINE_BITS];
      assign rot_sum[gi]    = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
      assign rot_idx[gi]    = (rot_sum[gi] >= (IDX_W+1)'(PORTS))
                              ? IDX_W'(rot_sum[gi] - (IDX_W+1)'(PORTS))
                              : rot_sum[gi][IDX_W-1:0];
    end
  endgenerate

  assign req = up_read | up_write;

`ifdef CACHE_ARB_WB_PRIO_EN
  assign cand = (|up_write) ? up_write : req;
`else
  assign cand = req;
`endif

  // Scan from farthest to nearest so the slot closest to the rr pointer wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (cand[rot_idx[k]]) begin
        pick_found = 1'b1;
        pick_idx   = rot_idx[k];
      end
    end
  end

  assign busy    = (state_reg == BUSY);
  assign g_req   = req[grant_idx_reg];
  assign g_write = up_write[grant_idx_reg];
  assign g_read  = up_read[grant_idx_reg] & ~g_write;
  assign rr_inc  = (grant_idx_reg == IDX_W'(PORTS - 1)) ? '0 : grant_idx_reg + IDX_W'(1);

  assign down_read      = busy & g_read;
  assign down_write     = busy & g_write;
  assign down_address   = slot_addr[grant_idx_reg];
  assign down_writedata = slot_wdata[grant_idx_reg];
  assign up_readdata    = down_readdata;
  assign grant_valid    = busy;
  assign grant_idx      = grant_idx_reg;

  always_comb begin
    up_waitrequest = '1;
    if (busy) begin
      up_waitrequest[grant_idx_reg] = down_waitrequest;
    end
  end

  // Leaving BUSY covers both a completed access and the owner withdrawing its request.
  always_comb begin
    state_next     = state_reg;
    grant_idx_next = grant_idx_reg;
    rr_ptr_next    = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next     = BUSY;
          grant_idx_next = pick_idx;
        end
      end
      BUSY: begin
        if (!g_req || !down_waitrequest) begin
          state_next  = IDLE;
          rr_ptr_next = rr_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      grant_idx_reg <= grant_idx_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scenarios plus randomized Avalon traffic checked against a
// behavioural owner/rr-pointer model of the arbiter; honours CACHE_ARB_WB_PRIO_EN.
module tb_cache_mem_arbiter;
  localparam int PORTS     = 4;
  localparam int LINE_BITS = 128;
  localparam int ADDR_BITS = 32;
  localparam int IW        = $clog2(PORTS);

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [PORTS*ADDR_BITS-1:0] up_address = '0;
  logic [PORTS-1:0]           up_read = '0;
  logic [PORTS-1:0]           up_write = '0;
  logic [PORTS*LINE_BITS-1:0] up_writedata = '0;
  logic [PORTS-1:0]           up_waitrequest;
  logic [LINE_BITS-1:0]       up_readdata;
  logic [ADDR_BITS-1:0]       down_address;
  logic                       down_read, down_write;
  logic [LINE_BITS-1:0]       down_writedata;
  logic                       down_waitrequest = 1'b0;
  logic [LINE_BITS-1:0]       down_readdata = '0;
  logic                       grant_valid;
  logic [IW-1:0]              grant_idx;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.PORTS(PORTS), .LINE_BITS(LINE_BITS), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_address(up_address), .up_read(up_read), .up_write(up_write),
    .up_writedata(up_writedata), .up_waitrequest(up_waitrequest), .up_readdata(up_readdata),
    .down_address(down_address), .down_read(down_read), .down_write(down_write),
    .down_writedata(down_writedata), .down_waitrequest(down_waitrequest),
    .down_readdata(down_readdata), .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  int checks = 0;
  int errors = 0;
  int ntx = 0;

  task automatic check(input string tag, input logic [LINE_BITS-1:0] got, input logic [LINE_BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the port (if anyone) and where the next search starts.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_rr = 0;

  function automatic int pick();
    logic [PORTS-1:0] c;
    c = up_read | up_write;
`ifdef CACHE_ARB_WB_PRIO_EN
    if (up_write != '0) c = up_write;
`endif
    for (int k = 0; k < PORTS; k++) begin
      if (c[(m_rr + k) % PORTS]) return (m_rr + k) % PORTS;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_rr = 0;
  endtask

  task automatic check_outputs();
    logic [PORTS-1:0] exp_wait;
    logic ew, er;
    exp_wait = '1; ew = 1'b0; er = 1'b0;
    if (m_busy) begin
      ew = up_write[m_owner];
      er = up_read[m_owner] & ~up_write[m_owner];
      exp_wait[m_owner] = down_waitrequest;
      check("grant_idx", LINE_BITS'(grant_idx), LINE_BITS'(m_owner));
      check("down_address", LINE_BITS'(down_address), LINE_BITS'(up_address[m_owner*ADDR_BITS +: ADDR_BITS]));
      if (ew) check("down_writedata", down_writedata, up_writedata[m_owner*LINE_BITS +: LINE_BITS]);
    end
    check("grant_valid", LINE_BITS'(grant_valid), LINE_BITS'(m_busy));
    check("down_read", LINE_BITS'(down_read), LINE_BITS'(er));
    check("down_write", LINE_BITS'(down_write), LINE_BITS'(ew));
    check("up_waitrequest", LINE_BITS'(up_waitrequest), LINE_BITS'(exp_wait));
    check("up_readdata", up_readdata, down_readdata);
  endtask

  task automatic model_step(output int done_slot);
    int p;
    done_slot = -1;
    if (!rst_n) begin
      model_reset();
    end else if (m_busy) begin
      if (!(up_read[m_owner] | up_write[m_owner]) || !down_waitrequest) begin
        if (up_read[m_owner] | up_write[m_owner]) done_slot = m_owner;
        m_busy = 1'b0;
        m_rr = (m_owner + 1) % PORTS;
      end
    end else begin
      p = pick();
      if (p >= 0) begin
        m_busy = 1'b1;
        m_owner = p;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
    check_outputs();
  endtask

  task automatic at_pos(output int done_slot);
    @(posedge clk); #1;
    model_step(done_slot);
  endtask

  task automatic do_reset();
    int d;
    rst_n = 1'b0;
    model_reset();
    at_neg();
    at_pos(d);
    rst_n = 1'b1;
  endtask

  initial begin
    int d;
    int order [6];
    logic [LINE_BITS-1:0] a5;
    order = '{0, 1, 3, 0, 1, 3};
    a5 = {16{8'hA5}};

    // Reset held with slot 1 reading; grant follows release by one cycle.
    up_read = 4'b0010;
    up_address[1*ADDR_BITS +: ADDR_BITS] = 32'h0000_0040;
    at_neg();
    check("t1_rst_down_read", LINE_BITS'(down_read), '0);
    check("t1_rst_waitreq", LINE_BITS'(up_waitrequest), LINE_BITS'(4'b1111));
    check("t1_rst_grant_idx", LINE_BITS'(grant_idx), '0);
    at_pos(d);
    rst_n = 1'b1;
    at_neg();
    check("t1_idle_grant_valid", LINE_BITS'(grant_valid), '0);
    at_pos(d);
    at_neg();
    check("t1_grant_idx", LINE_BITS'(grant_idx), LINE_BITS'(1));
    check("t1_down_read", LINE_BITS'(down_read), LINE_BITS'(1));
    at_pos(d);
    up_read = '0;

    // Slot 2 read with three wait states.
    up_read = 4'b0100;
    up_address[2*ADDR_BITS +: ADDR_BITS] = 32'h0000_1230;
    down_waitrequest = 1'b1;
    at_neg();
    at_pos(d);
    for (int w = 0; w < 3; w++) begin
      at_neg();
      check("t2_wait_slot2", LINE_BITS'(up_waitrequest[2]), LINE_BITS'(1));
      check("t2_down_address", LINE_BITS'(down_address), LINE_BITS'(32'h0000_1230));
      at_pos(d);
    end
    down_waitrequest = 1'b0;
    down_readdata = a5;
    at_neg();
    check("t2_done_waitreq", LINE_BITS'(up_waitrequest), LINE_BITS'(4'b1011));
    check("t2_readdata", up_readdata, a5);
    at_pos(d);
    up_read = '0;
    at_neg();
    check("t2_released", LINE_BITS'(grant_valid), '0);
    at_pos(d);

    // Slots 0,1,3 requesting continuously with zero wait states.
    do_reset();
    up_read = 4'b1011;
    for (int c = 0; c < 12; c++) begin
      at_neg();
      check("t3_grant_valid", LINE_BITS'(grant_valid), LINE_BITS'(c % 2));
      if (c % 2 == 1) check("t3_order", LINE_BITS'(grant_idx), LINE_BITS'(order[c/2]));
      at_pos(d);
    end
    up_read = '0;

    // Slot 0 read vs slot 3 write from rr pointer 0.
    do_reset();
    up_read = 4'b0001;
    up_write = 4'b1000;
    at_neg();
    at_pos(d);
    at_neg();
`ifdef CACHE_ARB_WB_PRIO_EN
    check("t4_first_grant", LINE_BITS'(grant_idx), LINE_BITS'(3));
`else
    check("t4_first_grant", LINE_BITS'(grant_idx), LINE_BITS'(0));
`endif
    at_pos(d);
    up_read = '0;
    up_write = '0;
    at_neg();
    at_pos(d);

    // Slot 1 withdraws while stalled; the next search starts at slot 2.
    do_reset();
    up_read = 4'b0010;
    down_waitrequest = 1'b1;
    at_neg();
    at_pos(d);
    at_neg();
    check("t5_grant_idx", LINE_BITS'(grant_idx), LINE_BITS'(1));
    at_pos(d);
    up_read = '0;
    at_neg();
    check("t5_abort_waitreq", LINE_BITS'(up_waitrequest), LINE_BITS'(4'b1111));
    check("t5_abort_no_read", LINE_BITS'(down_read), '0);
    at_pos(d);
    check("t5_no_completion", LINE_BITS'(d), LINE_BITS'(-1));
    at_neg();
    check("t5_released", LINE_BITS'(grant_valid), '0);
    down_waitrequest = 1'b0;
    up_read = 4'b0101;
    at_pos(d);
    at_neg();
    check("t5_rr_next", LINE_BITS'(grant_idx), LINE_BITS'(2));
    at_pos(d);
    up_read = '0;

    // Asynchronous reset in the middle of a stalled write.
    do_reset();
    up_write = 4'b0001;
    up_address[0 +: ADDR_BITS] = 32'h0000_8000;
    up_writedata[0 +: LINE_BITS] = {4{32'hDEAD_BEEF}};
    down_waitrequest = 1'b1;
    at_neg();
    at_pos(d);
    at_neg();
    check("t6_down_write", LINE_BITS'(down_write), LINE_BITS'(1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_down_write", LINE_BITS'(down_write), '0);
    check("t6_async_grant_valid", LINE_BITS'(grant_valid), '0);
    check("t6_async_waitreq", LINE_BITS'(up_waitrequest), LINE_BITS'(4'b1111));
    at_pos(d);
    up_write = '0;
    rst_n = 1'b1;

    // Randomized Avalon masters holding each request until accepted or withdrawn.
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (!(up_read[i] | up_write[i])) begin
          if ($urandom_range(0, 3) == 0) begin
            int kind;
            kind = $urandom_range(0, 4);
            up_write[i] = (kind >= 3);
            up_read[i]  = (kind < 3) || (kind == 4);
            up_address[i*ADDR_BITS +: ADDR_BITS] = $urandom;
            up_writedata[i*LINE_BITS +: LINE_BITS] = {$urandom, $urandom, $urandom, $urandom};
          end
        end else if (m_busy && m_owner == i && $urandom_range(0, 15) == 0) begin
          up_read[i] = 1'b0;
          up_write[i] = 1'b0;
        end
      end
      down_waitrequest = ($urandom_range(0, 2) == 0);
      down_readdata = {$urandom, $urandom, $urandom, $urandom};
      at_neg();
      at_pos(d);
      if (d >= 0) begin
        ntx++;
        $display("txn %0d: slot %0d %s addr=%h", ntx, d, up_write[d] ? "write" : "read",
                 up_address[d*ADDR_BITS +: ADDR_BITS]);
        up_read[d] = 1'b0;
        up_write[d] = 1'b0;
      end
    end
    up_read = '0;
    up_write = '0;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      at_pos(d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
